tag_lookup_ctrl: RTL and testbench

Direct-mapped cache tag lookup controller that sits immediately upstream of the synchronous-read tag RAM and drives its address, write-enable and data ports. It accepts one lookup request at a time, reads the indexed tag entry, compares it against the request tag and reports hit or miss. On a miss it performs a refill handshake, then writes the new valid tag into the RAM. After reset it clears every valid bit with a sweep.

---
 rtl/tag_lookup_ctrl.sv | 117 +++++++++++
 tb/tb_tag_lookup_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// Direct-mapped cache tag lookup controller: clears the tag RAM after reset,
// serves one lookup at a time and refills the indexed entry on a miss.
module tag_lookup_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 6,
  parameter int DWIDTH = 7
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AWIDTH+TWIDTH-1:0] req_addr,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [AWIDTH-1:0]        resp_index,
  output logic                     refill_req,
  output logic [AWIDTH+TWIDTH-1:0] refill_addr,
  input  logic                     refill_ack,
  output logic [15:0]              hit_count,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [DWIDTH-1:0]        ram_din,
  output logic                     ram_we,
  input  logic [DWIDTH-1:0]        ram_dout,
  output logic [2:0]               dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE. resp_valid is a
  // single-cycle pulse with no backpressure. refill_req is held until
  // refill_ack is sampled high.

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] LOOKUP = 3'd2;
  localparam logic [2:0] REFILL = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  localparam logic [AWIDTH-1:0] LAST_INDEX = AWIDTH'((1 << AWIDTH) - 1);

  logic [2:0]               state;
  logic [2:0]               state_nxt;
  logic [AWIDTH-1:0]        cnt;
  logic [AWIDTH+TWIDTH-1:0] lat_addr;
  logic                     hit_q;
  logic                     lookup_hit;
  logic [AWIDTH-1:0]        lat_index;
  logic [TWIDTH-1:0]        lat_tag;

  assign lat_index  = lat_addr[AWIDTH-1:0];
  assign lat_tag    = lat_addr[AWIDTH+TWIDTH-1:AWIDTH];
  // ram_dout holds the entry addressed on the accept edge while in LOOKUP.
  assign lookup_hit = ram_dout[DWIDTH-1] & (ram_dout[TWIDTH-1:0] == lat_tag);

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt == LAST_INDEX) state_nxt = IDLE;
      IDLE:    if (req_valid) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = lookup_hit ? RESP : REFILL;
      REFILL:  if (refill_ack) state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= INIT;
      cnt       <= '0;
      lat_addr  <= '0;
      hit_q     <= 1'b0;
      hit_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        INIT: cnt <= cnt + 1'b1;
        IDLE: if (req_valid) lat_addr <= req_addr;
        LOOKUP: begin
          hit_q <= lookup_hit;
          // Counted on entry to RESP so the count is current during the pulse.
          if (lookup_hit && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
        end
        WRITE: hit_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_addr = lat_index;
    ram_din  = '0;
    ram_we   = 1'b0;
    case (state)
      INIT: begin
        ram_addr = cnt;
        ram_we   = 1'b1;
      end
      IDLE: ram_addr = req_addr[AWIDTH-1:0];
      WRITE: begin
        ram_din = {1'b1, lat_tag};
        ram_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign resp_hit    = hit_q;
  assign resp_index  = lat_index;
  assign refill_req  = (state == REFILL);
  assign refill_addr = lat_addr;
  assign dbg_state   = state;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed and randomized bench for tag_lookup_ctrl with a behavioural tag RAM,
// a reference tag model and a response scoreboard.
module tb_tag_lookup_ctrl;

  localparam int AW = 3;
  localparam int TW = 6;
  localparam int DW = 7;

  logic          clock;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW+TW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_hit;
  logic [AW-1:0] resp_index;
  logic          refill_req;
  logic [AW+TW-1:0] refill_addr;
  logic          refill_ack;
  logic [15:0]   hit_count;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW:0]   exp_q[$];
  logic          mv[0:7];
  logic [TW-1:0] mt[0:7];
  logic [15:0]   exp_hits;

  tag_lookup_ctrl #(.AWIDTH(AW), .TWIDTH(TW), .DWIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_index(resp_index),
    .refill_req(refill_req), .refill_addr(refill_addr), .refill_ack(refill_ack),
    .hit_count(hit_count),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous-read tag RAM
  logic [DW-1:0] ram [0:7];
  always @(posedge clock) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // scoreboard: pop one expected {hit, index} per response pulse
  always @(negedge clock) begin
    if (reset_n && resp_valid) begin
      chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("resp_hit_index", {resp_hit, resp_index}, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    exp_hits = 16'd0;
    @(negedge clock);
    chk("rst_refill_req", refill_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_index", resp_index, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_ram_we", ram_we, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("sweep_we", ram_we, 1);
      chk("sweep_addr", ram_addr, i);
      chk("sweep_din", ram_din, 0);
      chk("sweep_ready_low", req_ready, 0);
      @(negedge clock);
    end
    chk("sweep_ready_high", req_ready, 1);
    chk("sweep_hit_count", hit_count, 0);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("req_ready_wait", req_ready, 1);
  endtask

  // driver: one lookup, acking any refill on its (ack_delay+1)-th cycle
  task automatic send_req(input logic [AW+TW-1:0] addr, input int ack_delay);
    logic [AW-1:0] idx;
    logic [TW-1:0] tag;
    logic          exp_hit;
    int            lat;
    int            rc;
    int            wc;
    logic          done;
    idx     = addr[AW-1:0];
    tag     = addr[AW+TW-1:AW];
    exp_hit = mv[idx] && (mt[idx] == tag);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = addr;
    exp_q.push_back({exp_hit, idx});
    @(posedge clock);
    lat = 0; rc = 0; wc = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      req_valid = 1'b0;
      if (refill_req) begin
        rc++;
        chk("refill_addr", refill_addr, addr);
        refill_ack = (rc == ack_delay + 1);
      end else begin
        refill_ack = 1'b0;
      end
      if (ram_we) begin
        wc++;
        chk("write_addr", ram_addr, idx);
        chk("write_din", ram_din, {1'b1, tag});
      end
      if (resp_valid) done = 1'b1;
    end
    refill_ack = 1'b0;
    chk("resp_seen", done, 1);
    chk("latency", lat, exp_hit ? 2 : 4 + ack_delay);
    chk("refill_cycles", rc, exp_hit ? 0 : ack_delay + 1);
    chk("write_count", wc, exp_hit ? 0 : 1);
    if (exp_hit) begin
      if (exp_hits != 16'hFFFF) exp_hits = exp_hits + 16'd1;
    end else begin
      mv[idx] = 1'b1;
      mt[idx] = tag;
    end
    @(negedge clock);
    chk("hit_count", hit_count, exp_hits);
  endtask

  initial begin
    logic [AW+TW-1:0] a;
    int w;
    req_valid  = 1'b0;
    req_addr   = '0;
    refill_ack = 1'b0;
    do_reset();

    send_req(9'h0AB, 3);   // cold miss, index 3 tag 6'h15
    send_req(9'h0AB, 0);   // hit on the just-refilled entry
    send_req(9'h0F3, 0);   // conflict miss, writes 7'h5E at index 3
    send_req(9'h0AB, 1);   // evicted tag misses again
    send_req(9'h0AB, 0);

    // reset while the refill is outstanding
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 9'h0F3;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    w = 0;
    while (!refill_req && w < 10) begin
      @(negedge clock);
      w++;
    end
    chk("refill_before_reset", refill_req, 1);
    do_reset();
    send_req(9'h0AB, 0);   // entry cleared by the sweep, so this misses

    // refill_ack in IDLE is ignored
    for (int i = 0; i < 3; i++) begin
      refill_ack = 1'b1;
      @(negedge clock);
      refill_ack = 1'b0;
      chk("idle_ack_ready", req_ready, 1);
      chk("idle_ack_state", dbg_state, 3'd1);
      chk("idle_ack_refill", refill_req, 0);
      chk("idle_ack_we", ram_we, 0);
    end
    send_req(9'h0AB, 0);

    for (int k = 0; k < 10; k++) begin
      a[AW-1:0]     = AW'($urandom_range(4, 6));
      a[AW+TW-1:AW] = ($urandom_range(0, 1) == 0) ? 6'h2A : 6'h15;
      send_req(a, $urandom_range(0, 2));
    end

    // saturation: preload the counter, then one more hit
    force dut.hit_count = 16'hFFFF;
    @(negedge clock);
    release dut.hit_count;
    exp_hits = 16'hFFFF;
    @(negedge clock);
    chk("sat_preload", hit_count, 16'hFFFF);
    send_req(9'h0AB, 0);
    send_req(9'h0AB, 0);

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
